commit_trace_compactor: RTL and testbench
=========================================

COMMIT_TRACE_COMPACTOR -- requirements
Module: commit_trace_compactor

Interface
REQ-001 SHALL have parameter RETIRE_WIDTH, default 4, number of commit lanes (1..8).
REQ-002 SHALL have parameter DEPTH, default 16, trace FIFO entries (power of 2, >= RETIRE_WIDTH).
REQ-003 SHALL have parameters XLEN 64, ADDR_BITS 40, LREG_SZ 5, VLEN 256, which set the data, PC, register-index and vector widths.
REQ-004 Clock and reset: single clock; reset is synchronous and active-low.
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous reset, asserted when 0.
REQ-007 hartid  in  8  hart identifier, registered into every entry.
REQ-008 commit_valid  in  RETIRE_WIDTH  per-lane architectural commit valid.
REQ-009 commit_pc / commit_inst / commit_wdata / commit_ldst / commit_rtype  in  RETIRE_WIDTH x {ADDR_BITS, 32, XLEN, LREG_SZ, 3}  per-lane commit fields, packed lane 0 at LSBs.
REQ-010 trace_valid  out  1  head entry available.
REQ-011 trace_ready  in  1  consumer accepts head.
REQ-012 trace_pc/inst/wdata/ldst/rtype/hartid  out  matching widths  head entry fields.
REQ-013 trace_seq  out  64  commit sequence number of the head entry.
REQ-014 overflow  out  1  sticky: at least one commit group dropped.
REQ-015 drop_count  out  32  total commits dropped, saturating.

Function
REQ-016 Each cycle, the set lanes of commit_valid SHALL be compacted in ascending lane order into consecutive FIFO slots; the lowest valid lane is written first.
REQ-017 A group SHALL be accepted only if count - pop + popcount(commit_valid) <= DEPTH, where pop = trace_valid & trace_ready in that same cycle; otherwise the whole group is dropped, never split.
REQ-018 On a drop, overflow SHALL set to 1 on the next edge and drop_count SHALL add popcount, saturating at 0xFFFF_FFFF.
REQ-019 A 64-bit sequence counter SHALL advance by popcount(commit_valid) every cycle, whether the group is accepted or dropped; each accepted lane k (k-th valid) gets seq = counter + k, so dropped commits appear as gaps in trace_seq.
REQ-020 The write-to-output latency SHALL be 1 cycle: a group accepted into an empty FIFO drives trace_valid=1 on the next cycle.
REQ-021 trace_valid SHALL equal (count != 0); head fields SHALL stay stable while trace_valid & !trace_ready.
REQ-022 Simultaneous push and pop SHALL be legal at any occupancy, including full with a pop.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-024 A commit_valid of all zeros SHALL cause no push, no drop and no sequence advance.

Reset
REQ-025 While reset=0: count, pointers and the sequence counter SHALL be 0, overflow=0, drop_count=0 and trace_valid=0; FIFO contents are not reset.
REQ-026 Reset asserted mid-operation SHALL discard all queued entries at the next edge; the commit inputs in that cycle are ignored.

Configuration
REQ-027 Macro COMMIT_TRACE_VEC_EN defined: the block SHALL add commit_vec_wdata (in, RETIRE_WIDTH x VLEN), commit_vec_wmask (in, RETIRE_WIDTH x 8), trace_vec_wdata (out, VLEN) and trace_vec_wmask (out, 8), and carry these fields through the FIFO with the same compaction.
REQ-028 Macro undefined: those ports and storage SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package commit_trace_pkg SHALL hold the entry struct typedef, the rtype encodings (RT_FIX=0, RT_FLT=1, RT_PAS=2, RT_VEC=3) and the sequence and drop counter widths.
REQ-030 The multi-push, single-pop circular buffer SHALL be the sub-module commit_trace_fifo; the compaction, sequence and drop logic SHALL live in the top module.

Verification
REQ-031 Valid=4'b1010 into an empty FIFO, ready=1 -> next cycle lane 1 out with seq 0, then lane 3 with seq 1, then trace_valid=0.
REQ-032 Hold ready=0 and push 4'b1111 x4 (16 entries), then push 4'b0011 -> dropped; overflow=1, drop_count=2, count stays 16.
REQ-033 Full FIFO, ready=1, push 4'b0001 -> accepted (16-1+1 <= 16), count stays 16, no drop.
REQ-034 Drop 2 commits, then accept 4'b0001 -> that entry has trace_seq = previous seq + 3 (gap of 2).
REQ-035 Assert reset=0 with 5 entries queued -> next cycle trace_valid=0, overflow=0, drop_count=0; the first post-reset entry has seq 0.
REQ-036 With COMMIT_TRACE_VEC_EN and lane 2 only valid, vec_wdata=all-ones and wmask=8'hFF -> output carries the same vec_wdata and wmask with lane 2's PC.

Source files
------------

// File: rtl/commit_trace_compactor_pkg.sv
// Shared types for the commit trace compactor: rtype encodings, counter widths
// and the fixed-width portion of a trace entry.
package commit_trace_pkg;

  localparam int SEQ_W  = 64;
  localparam int DROP_W = 32;

  typedef enum logic [2:0] {
    RT_FIX = 3'd0,
    RT_FLT = 3'd1,
    RT_PAS = 3'd2,
    RT_VEC = 3'd3
  } rtype_e;

  // Width-independent fields of an entry; the parameter-sized fields ride above it.
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [7:0]       hartid;
    logic [31:0]      inst;
    rtype_e           rtype;
  } trace_entry_t;

  localparam int META_W = $bits(trace_entry_t);

endpackage

// File: rtl/commit_trace_compactor_if.sv
// Trace output stream of the compactor: head entry fields plus valid/ready.
// Vector fields exist only when COMMIT_TRACE_VEC_EN is defined.
interface commit_trace_compactor_if #(
  parameter int XLEN      = 64,
  parameter int ADDR_BITS = 40,
  parameter int LREG_SZ   = 5
`ifdef COMMIT_TRACE_VEC_EN
  ,
  parameter int VLEN      = 256
`endif
);
  logic                 trace_valid;
  logic                 trace_ready;
  logic [ADDR_BITS-1:0] trace_pc;
  logic [31:0]          trace_inst;
  logic [XLEN-1:0]      trace_wdata;
  logic [LREG_SZ-1:0]   trace_ldst;
  logic [2:0]           trace_rtype;
  logic [7:0]           trace_hartid;
  logic [63:0]          trace_seq;
`ifdef COMMIT_TRACE_VEC_EN
  logic [VLEN-1:0]      trace_vec_wdata;
  logic [7:0]           trace_vec_wmask;
`endif

  modport master (
    output trace_valid, trace_pc, trace_inst, trace_wdata, trace_ldst,
           trace_rtype, trace_hartid, trace_seq,
`ifdef COMMIT_TRACE_VEC_EN
    output trace_vec_wdata, trace_vec_wmask,
`endif
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_pc, trace_inst, trace_wdata, trace_ldst,
           trace_rtype, trace_hartid, trace_seq,
`ifdef COMMIT_TRACE_VEC_EN
    input  trace_vec_wdata, trace_vec_wmask,
`endif
    output trace_ready
  );

endinterface

// File: rtl/commit_trace_compactor_fifo.sv
// Circular buffer accepting up to LANES pre-compacted entries per cycle and
// releasing one per cycle; head is read straight from the storage array.
module commit_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LANES = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [$clog2(LANES+1)-1:0]       push_cnt,
  input  logic [LANES-1:0][WIDTH-1:0]      push_data,
  input  logic                             pop,
  output logic                             head_valid,
  output logic [WIDTH-1:0]                 head_data,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        if (i < int'(push_cnt)) begin
          mem[wr_ptr_reg + AW'(i)] <= push_data[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push_cnt);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(push_cnt) - CW'(pop);
    end
  end

  assign head_valid = (count_reg != '0);
  assign head_data  = mem[rd_ptr_reg];
  assign count      = count_reg;

endmodule

// File: rtl/commit_trace_compactor.sv
// Compacts per-lane commits into a trace FIFO, numbering every commit and
// dropping whole groups that do not fit. Vector payload: COMMIT_TRACE_VEC_EN.
module commit_trace_compactor
  import commit_trace_pkg::*;
#(
  parameter int RETIRE_WIDTH = 4,
  parameter int DEPTH        = 16,
  parameter int XLEN         = 64,
  parameter int ADDR_BITS    = 40,
  parameter int LREG_SZ      = 5,
  parameter int VLEN         = 256
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [7:0]                        hartid,
  input  logic [RETIRE_WIDTH-1:0]           commit_valid,
  input  logic [RETIRE_WIDTH*ADDR_BITS-1:0] commit_pc,
  input  logic [RETIRE_WIDTH*32-1:0]        commit_inst,
  input  logic [RETIRE_WIDTH*XLEN-1:0]      commit_wdata,
  input  logic [RETIRE_WIDTH*LREG_SZ-1:0]   commit_ldst,
  input  logic [RETIRE_WIDTH*3-1:0]         commit_rtype,
`ifdef COMMIT_TRACE_VEC_EN
  input  logic [RETIRE_WIDTH*VLEN-1:0]      commit_vec_wdata,
  input  logic [RETIRE_WIDTH*8-1:0]         commit_vec_wmask,
`endif
  commit_trace_compactor_if.master          trace,
  output logic                              overflow,
  output logic [DROP_W-1:0]                 drop_count
);

`ifdef COMMIT_TRACE_VEC_EN
  localparam int VEC_W = VLEN + 8;
`else
  localparam int VEC_W = VLEN * 0;  // vector fields vanish when the feature is off
`endif
  localparam int BODY_W  = VEC_W + ADDR_BITS + XLEN + LREG_SZ;
  localparam int ENTRY_W = BODY_W + META_W;
  localparam int PCW     = $clog2(RETIRE_WIDTH+1);
  localparam int CW      = $clog2(DEPTH+1);
  localparam int DSW     = DROP_W + 1;

  trace_entry_t                           lane_meta [RETIRE_WIDTH];
  logic [BODY_W-1:0]                      lane_body [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0][ENTRY_W-1:0]   slot_data;
  logic [PCW-1:0]                         grp_cnt;
  logic [PCW-1:0]                         push_cnt;
  logic [CW-1:0]                          fifo_count;
  logic                                   fifo_valid;
  logic [ENTRY_W-1:0]                     head_data;
  trace_entry_t                           head_meta;
  logic                                   pop;
  logic                                   accept;
  logic [31:0]                            room_need;
  logic [DSW-1:0]                         drop_sum;

  logic [SEQ_W-1:0]  seq_reg;
  logic              overflow_reg;
  logic [DROP_W-1:0] drop_reg;

  genvar gi;
  generate
    for (gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_lane
      assign lane_meta[gi] = '{seq:    '0,
                               hartid: hartid,
                               inst:   commit_inst[gi*32 +: 32],
                               rtype:  rtype_e'(commit_rtype[gi*3 +: 3])};
`ifdef COMMIT_TRACE_VEC_EN
      assign lane_body[gi] = {commit_vec_wdata[gi*VLEN +: VLEN],
                              commit_vec_wmask[gi*8 +: 8],
                              commit_pc[gi*ADDR_BITS +: ADDR_BITS],
                              commit_wdata[gi*XLEN +: XLEN],
                              commit_ldst[gi*LREG_SZ +: LREG_SZ]};
`else
      assign lane_body[gi] = {commit_pc[gi*ADDR_BITS +: ADDR_BITS],
                              commit_wdata[gi*XLEN +: XLEN],
                              commit_ldst[gi*LREG_SZ +: LREG_SZ]};
`endif
    end
  endgenerate

  // The k-th valid lane lands in slot k and is numbered seq_reg + k.
  always_comb begin
    int k;
    trace_entry_t meta;
    k         = 0;
    meta      = '0;
    slot_data = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      if (commit_valid[i]) begin
        meta         = lane_meta[i];
        meta.seq     = seq_reg + SEQ_W'(k);
        slot_data[k] = {lane_body[i], meta};
        k            = k + 1;
      end
    end
    grp_cnt = PCW'(k);
  end

  // Room check counts the slot freed by a same-cycle pop, so full+pop can accept.
  assign pop       = fifo_valid & trace.trace_ready;
  assign room_need = 32'(fifo_count) - 32'(pop) + 32'(grp_cnt);
  assign accept    = (room_need <= 32'(DEPTH));
  assign push_cnt  = accept ? grp_cnt : '0;
  assign drop_sum  = {1'b0, drop_reg} + DSW'(grp_cnt);

  always_ff @(posedge clock) begin
    if (!reset) begin
      seq_reg      <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
    end else begin
      seq_reg <= seq_reg + SEQ_W'(grp_cnt);
      if (!accept) begin
        overflow_reg <= 1'b1;
        drop_reg     <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      end
    end
  end

  commit_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .LANES (RETIRE_WIDTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_cnt   (push_cnt),
    .push_data  (slot_data),
    .pop        (pop),
    .head_valid (fifo_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  assign head_meta          = trace_entry_t'(head_data[META_W-1:0]);
  assign trace.trace_valid  = fifo_valid;
  assign trace.trace_seq    = head_meta.seq;
  assign trace.trace_hartid = head_meta.hartid;
  assign trace.trace_inst   = head_meta.inst;
  assign trace.trace_rtype  = head_meta.rtype;
  assign trace.trace_ldst   = head_data[META_W +: LREG_SZ];
  assign trace.trace_wdata  = head_data[META_W+LREG_SZ +: XLEN];
  assign trace.trace_pc     = head_data[META_W+LREG_SZ+XLEN +: ADDR_BITS];
`ifdef COMMIT_TRACE_VEC_EN
  assign trace.trace_vec_wmask = head_data[META_W+LREG_SZ+XLEN+ADDR_BITS +: 8];
  assign trace.trace_vec_wdata = head_data[META_W+LREG_SZ+XLEN+ADDR_BITS+8 +: VLEN];
`endif

  assign overflow   = overflow_reg;
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_commit_trace_compactor.sv
// Directed bench for commit_trace_compactor at default parameters; the vector
// check is compiled only with COMMIT_TRACE_VEC_EN.
module tb_commit_trace_compactor;

  localparam int RW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    hartid = 8'h5A;
  logic [RW-1:0] commit_valid = '0;
  logic [RW*40-1:0] commit_pc = '0;
  logic [RW*32-1:0] commit_inst = '0;
  logic [RW*64-1:0] commit_wdata = '0;
  logic [RW*5-1:0]  commit_ldst = '0;
  logic [RW*3-1:0]  commit_rtype = '0;
`ifdef COMMIT_TRACE_VEC_EN
  logic [RW*256-1:0] commit_vec_wdata = '0;
  logic [RW*8-1:0]   commit_vec_wmask = '0;
`endif
  logic        overflow;
  logic [31:0] drop_count;

  int errors = 0;
  int checks = 0;

`ifdef COMMIT_TRACE_VEC_EN
  commit_trace_compactor_if #(.XLEN(64), .ADDR_BITS(40), .LREG_SZ(5), .VLEN(256)) trace_if ();
`else
  commit_trace_compactor_if #(.XLEN(64), .ADDR_BITS(40), .LREG_SZ(5)) trace_if ();
`endif

  commit_trace_compactor #(
    .RETIRE_WIDTH (RW),
    .DEPTH        (16),
    .XLEN         (64),
    .ADDR_BITS    (40),
    .LREG_SZ      (5),
    .VLEN         (256)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .hartid       (hartid),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_inst  (commit_inst),
    .commit_wdata (commit_wdata),
    .commit_ldst  (commit_ldst),
    .commit_rtype (commit_rtype),
`ifdef COMMIT_TRACE_VEC_EN
    .commit_vec_wdata (commit_vec_wdata),
    .commit_vec_wmask (commit_vec_wmask),
`endif
    .trace        (trace_if),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [39:0] pc_of(input int tag, input int lane);
    return 40'h8000_0000 + 40'(tag * 64) + 40'(lane * 4);
  endfunction

  function automatic logic [31:0] inst_of(input int tag, input int lane);
    return 32'hC000_0000 | 32'(tag << 8) | 32'(lane);
  endfunction

  function automatic logic [63:0] wdata_of(input int tag, input int lane);
    return 64'hD000_0000_0000_0000 | 64'(tag << 16) | 64'(lane);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_group(input logic [RW-1:0] v, input int tag);
    commit_valid = v;
    for (int i = 0; i < RW; i++) begin
      commit_pc[i*40 +: 40]    = pc_of(tag, i);
      commit_inst[i*32 +: 32]  = inst_of(tag, i);
      commit_wdata[i*64 +: 64] = wdata_of(tag, i);
      commit_ldst[i*5 +: 5]    = 5'(i + 1);
      commit_rtype[i*3 +: 3]   = 3'(i);
    end
  endtask

  task automatic check_head(input string tag, input int gtag, input int lane, input int seq);
    check_eq({tag, "_valid"}, 64'(trace_if.trace_valid), 64'd1);
    check_eq({tag, "_pc"}, 64'(trace_if.trace_pc), 64'(pc_of(gtag, lane)));
    check_eq({tag, "_seq"}, trace_if.trace_seq, 64'(seq));
  endtask

  initial begin
    trace_if.trace_ready = 1'b0;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", 64'(trace_if.trace_valid), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_drop", 64'(drop_count), 64'd0);
    reset = 1'b1;

    // 4'b1010 into empty FIFO with ready=1: lane 1 then lane 3
    trace_if.trace_ready = 1'b1;
    set_group(4'b1010, 1);
    tick();
    set_group(4'b0000, 0);
    check_head("sparse_first", 1, 1, 0);
    check_eq("sparse_inst", 64'(trace_if.trace_inst), 64'(inst_of(1, 1)));
    check_eq("sparse_wdata", trace_if.trace_wdata, wdata_of(1, 1));
    check_eq("sparse_ldst", 64'(trace_if.trace_ldst), 64'd2);
    check_eq("sparse_rtype", 64'(trace_if.trace_rtype), 64'd1);
    check_eq("sparse_hartid", 64'(trace_if.trace_hartid), 64'h5A);
    tick();
    check_head("sparse_second", 1, 3, 1);
    tick();
    check_eq("sparse_empty", 64'(trace_if.trace_valid), 64'd0);

    // Idle cycles with zero valid must not advance the sequence
    tick();
    tick();

    // Fill 16 entries with ready=0, seq 2..17
    trace_if.trace_ready = 1'b0;
    for (int t = 2; t <= 5; t++) begin
      set_group(4'b1111, t);
      tick();
    end
    check_eq("full_no_overflow", 64'(overflow), 64'd0);
    check_eq("full_no_drop", 64'(drop_count), 64'd0);
    set_group(4'b0011, 6);
    tick();
    check_eq("drop_overflow", 64'(overflow), 64'd1);
    check_eq("drop_count2", 64'(drop_count), 64'd2);
    check_head("stall_head", 2, 0, 2);

    // Full with pop accepts a single commit; seq jumps 17 -> 20
    trace_if.trace_ready = 1'b1;
    set_group(4'b0001, 7);
    tick();
    check_eq("fullpop_drop", 64'(drop_count), 64'd2);
    check_head("fullpop_head", 2, 1, 3);

    // Full with pop cannot fit two commits
    set_group(4'b0011, 8);
    tick();
    check_eq("fullpop2_drop", 64'(drop_count), 64'd4);
    check_eq("fullpop2_overflow", 64'(overflow), 64'd1);
    set_group(4'b0000, 0);

    // Drain: remaining 15 entries, last one shows the gap
    for (int t = 2; t <= 5; t++) begin
      for (int l = 0; l < 4; l++) begin
        if (2 + (t - 2) * 4 + l >= 4) begin
          check_head($sformatf("drain_t%0d_l%0d", t, l), t, l, 2 + (t - 2) * 4 + l);
          tick();
        end
      end
    end
    check_head("drain_gap", 7, 0, 20);
    tick();
    check_eq("drain_empty", 64'(trace_if.trace_valid), 64'd0);

    // Queue 5 entries, then reset mid-operation with commits presented
    trace_if.trace_ready = 1'b0;
    set_group(4'b1111, 9);
    tick();
    set_group(4'b0001, 10);
    tick();
    check_eq("prerst_valid", 64'(trace_if.trace_valid), 64'd1);
    reset = 1'b0;
    set_group(4'b1111, 11);
    tick();
    check_eq("midrst_valid", 64'(trace_if.trace_valid), 64'd0);
    check_eq("midrst_overflow", 64'(overflow), 64'd0);
    check_eq("midrst_drop", 64'(drop_count), 64'd0);
    reset = 1'b1;
    set_group(4'b0000, 0);
    tick();
    check_eq("postrst_idle", 64'(trace_if.trace_valid), 64'd0);
    set_group(4'b0100, 12);
    tick();
    check_head("postrst_first", 12, 2, 0);

    // Push 4'b1001 while popping: lane 0 before lane 3
    trace_if.trace_ready = 1'b1;
    set_group(4'b1001, 13);
    tick();
    set_group(4'b0000, 0);
    check_head("pushpop_a", 13, 0, 1);
    tick();
    check_head("pushpop_b", 13, 3, 2);
    tick();
    check_eq("pushpop_empty", 64'(trace_if.trace_valid), 64'd0);

`ifdef COMMIT_TRACE_VEC_EN
    // Vector payload follows lane 2 through compaction
    trace_if.trace_ready = 1'b0;
    set_group(4'b0100, 14);
    commit_vec_wdata = '0;
    commit_vec_wmask = '0;
    commit_vec_wdata[2*256 +: 256] = '1;
    commit_vec_wmask[2*8 +: 8]     = 8'hFF;
    tick();
    set_group(4'b0000, 0);
    check_head("vec_head", 14, 2, 3);
    check_eq("vec_wdata_all", 64'(&trace_if.trace_vec_wdata), 64'd1);
    check_eq("vec_wdata_lo", trace_if.trace_vec_wdata[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("vec_wmask", 64'(trace_if.trace_vec_wmask), 64'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
